// File: rtl/data_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gpu_pkg
// Description : Shared types for the data-memory controller: channel FSM
//               states and address/data word types.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int C_ADDR_WIDTH = 8;
    localparam int C_DATA_WIDTH = 8;

    typedef logic [C_DATA_WIDTH-1:0] data_t;
    typedef logic [C_ADDR_WIDTH-1:0] data_memory_address_t;

    typedef enum logic [2:0] {
        CH_IDLE          = 3'd0,
        CH_READ_WAITING  = 3'd1,
        CH_WRITE_WAITING = 3'd2,
        CH_RELAY_READ    = 3'd3,
        CH_RELAY_WRITE   = 3'd4
    } mem_channel_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : data_mem_controller_if
// Description : LSU-side request/ack bus plus external memory channel bus.
//               slave = controller view, master = LSU/memory environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_controller_if #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = gpu_pkg::C_ADDR_WIDTH,
    parameter int DATA_WIDTH    = gpu_pkg::C_DATA_WIDTH
);
    logic [NUM_CONSUMERS-1:0]                 consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                 consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                 consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                 consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                  mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                  mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                  mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                  mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search over an eligible mask,
//               starting at rr_ptr and wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic [N-1:0]  eligible,
    input  logic [CW-1:0] rr_ptr,
    output logic          grant_valid,
    output logic [CW-1:0] grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && eligible[(int'(rr_ptr) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'((int'(rr_ptr) + k) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_controller
// Description : Round-robin arbitration of LSU read/write requests onto
//               NUM_CHANNELS external data-memory channels.
//               Optional macro DATA_MEM_CTRL_STATS_EN adds completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_controller
    import gpu_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = C_ADDR_WIDTH,
    parameter int DATA_WIDTH    = C_DATA_WIDTH
) (
    input  logic clk,
    input  logic reset,
    data_mem_controller_if.slave bus
`ifdef DATA_MEM_CTRL_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes
`endif
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    mem_channel_state_t r_ch_state        [NUM_CHANNELS];
    mem_channel_state_t w_ch_state_nxt    [NUM_CHANNELS];
    logic [CW-1:0]      r_ch_consumer     [NUM_CHANNELS];
    logic [CW-1:0]      w_ch_consumer_nxt [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] r_claimed, w_claimed_nxt;
    logic [CW-1:0]            r_rr_ptr, w_rr_ptr_nxt;

    logic [NUM_CHANNELS-1:0]                  r_mem_read_valid, w_mem_read_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  r_mem_read_address, w_mem_read_address_nxt;
    logic [NUM_CHANNELS-1:0]                  r_mem_write_valid, w_mem_write_valid_nxt;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  r_mem_write_address, w_mem_write_address_nxt;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  r_mem_write_data, w_mem_write_data_nxt;
    logic [NUM_CONSUMERS-1:0]                 r_consumer_read_ready, w_consumer_read_ready_nxt;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] r_consumer_read_data, w_consumer_read_data_nxt;
    logic [NUM_CONSUMERS-1:0]                 r_consumer_write_ready, w_consumer_write_ready_nxt;

    logic [NUM_CONSUMERS-1:0] w_eligible;
    logic                     w_grant_valid;
    logic [CW-1:0]            w_grant_idx;
    logic                     w_grant_taken;
`ifdef DATA_MEM_CTRL_STATS_EN
    logic [31:0] w_reads_done, w_writes_done;
    logic [31:0] r_stat_reads, r_stat_writes;
`endif

    assign w_eligible = (bus.consumer_read_valid | bus.consumer_write_valid) & ~r_claimed;

    rr_arbiter #(
        .N  (NUM_CONSUMERS),
        .CW (CW)
    ) u_rr_arbiter (
        .eligible    (w_eligible),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Channels are scanned in ascending order so the single grant per cycle
    // always lands on the lowest-index idle channel.
    always_comb begin
        w_ch_state_nxt             = r_ch_state;
        w_ch_consumer_nxt          = r_ch_consumer;
        w_claimed_nxt              = r_claimed;
        w_rr_ptr_nxt               = r_rr_ptr;
        w_mem_read_valid_nxt       = r_mem_read_valid;
        w_mem_read_address_nxt     = r_mem_read_address;
        w_mem_write_valid_nxt      = r_mem_write_valid;
        w_mem_write_address_nxt    = r_mem_write_address;
        w_mem_write_data_nxt       = r_mem_write_data;
        w_consumer_read_ready_nxt  = r_consumer_read_ready;
        w_consumer_read_data_nxt   = r_consumer_read_data;
        w_consumer_write_ready_nxt = r_consumer_write_ready;
        w_grant_taken              = 1'b0;
`ifdef DATA_MEM_CTRL_STATS_EN
        w_reads_done               = '0;
        w_writes_done              = '0;
`endif
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (r_ch_state[c])
                CH_IDLE: begin
                    if (w_grant_valid && !w_grant_taken) begin
                        w_grant_taken              = 1'b1;
                        w_claimed_nxt[w_grant_idx] = 1'b1;
                        w_rr_ptr_nxt               = (w_grant_idx == CW'(NUM_CONSUMERS - 1)) ?
                                                     '0 : w_grant_idx + 1'b1;
                        w_ch_consumer_nxt[c]       = w_grant_idx;
                        // Reads win when a consumer raises both valids.
                        if (bus.consumer_read_valid[w_grant_idx]) begin
                            w_mem_read_valid_nxt[c]   = 1'b1;
                            w_mem_read_address_nxt[c] = bus.consumer_read_address[w_grant_idx];
                            w_ch_state_nxt[c]         = CH_READ_WAITING;
                        end else begin
                            w_mem_write_valid_nxt[c]   = 1'b1;
                            w_mem_write_address_nxt[c] = bus.consumer_write_address[w_grant_idx];
                            w_mem_write_data_nxt[c]    = bus.consumer_write_data[w_grant_idx];
                            w_ch_state_nxt[c]          = CH_WRITE_WAITING;
                        end
                    end
                end
                CH_READ_WAITING: begin
                    if (bus.mem_read_ready[c]) begin
                        w_mem_read_valid_nxt[c]                        = 1'b0;
                        w_consumer_read_data_nxt[r_ch_consumer[c]]  = bus.mem_read_data[c];
                        w_consumer_read_ready_nxt[r_ch_consumer[c]] = 1'b1;
                        w_ch_state_nxt[c]                              = CH_RELAY_READ;
`ifdef DATA_MEM_CTRL_STATS_EN
                        w_reads_done = w_reads_done + 32'd1;
`endif
                    end
                end
                CH_WRITE_WAITING: begin
                    if (bus.mem_write_ready[c]) begin
                        w_mem_write_valid_nxt[c]                        = 1'b0;
                        w_consumer_write_ready_nxt[r_ch_consumer[c]] = 1'b1;
                        w_ch_state_nxt[c]                               = CH_RELAY_WRITE;
`ifdef DATA_MEM_CTRL_STATS_EN
                        w_writes_done = w_writes_done + 32'd1;
`endif
                    end
                end
                CH_RELAY_READ: begin
                    if (!bus.consumer_read_valid[r_ch_consumer[c]]) begin
                        w_consumer_read_ready_nxt[r_ch_consumer[c]] = 1'b0;
                        w_claimed_nxt[r_ch_consumer[c]]             = 1'b0;
                        w_ch_state_nxt[c]                              = CH_IDLE;
                    end
                end
                CH_RELAY_WRITE: begin
                    if (!bus.consumer_write_valid[r_ch_consumer[c]]) begin
                        w_consumer_write_ready_nxt[r_ch_consumer[c]] = 1'b0;
                        w_claimed_nxt[r_ch_consumer[c]]              = 1'b0;
                        w_ch_state_nxt[c]                               = CH_IDLE;
                    end
                end
                default: w_ch_state_nxt[c] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_ch_state[c]    <= CH_IDLE;
                r_ch_consumer[c] <= '0;
            end
            r_claimed              <= '0;
            r_rr_ptr               <= '0;
            r_mem_read_valid       <= '0;
            r_mem_read_address     <= '0;
            r_mem_write_valid      <= '0;
            r_mem_write_address    <= '0;
            r_mem_write_data       <= '0;
            r_consumer_read_ready  <= '0;
            r_consumer_read_data   <= '0;
            r_consumer_write_ready <= '0;
        end else begin
            r_ch_state             <= w_ch_state_nxt;
            r_ch_consumer          <= w_ch_consumer_nxt;
            r_claimed              <= w_claimed_nxt;
            r_rr_ptr               <= w_rr_ptr_nxt;
            r_mem_read_valid       <= w_mem_read_valid_nxt;
            r_mem_read_address     <= w_mem_read_address_nxt;
            r_mem_write_valid      <= w_mem_write_valid_nxt;
            r_mem_write_address    <= w_mem_write_address_nxt;
            r_mem_write_data       <= w_mem_write_data_nxt;
            r_consumer_read_ready  <= w_consumer_read_ready_nxt;
            r_consumer_read_data   <= w_consumer_read_data_nxt;
            r_consumer_write_ready <= w_consumer_write_ready_nxt;
        end
    end

`ifdef DATA_MEM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else begin
            r_stat_reads  <= r_stat_reads + w_reads_done;
            r_stat_writes <= r_stat_writes + w_writes_done;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
`endif

    assign bus.mem_read_valid       = r_mem_read_valid;
    assign bus.mem_read_address     = r_mem_read_address;
    assign bus.mem_write_valid      = r_mem_write_valid;
    assign bus.mem_write_address    = r_mem_write_address;
    assign bus.mem_write_data       = r_mem_write_data;
    assign bus.consumer_read_ready  = r_consumer_read_ready;
    assign bus.consumer_read_data   = r_consumer_read_data;
    assign bus.consumer_write_ready = r_consumer_write_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_controller
// Description : Directed self-checking bench for data_mem_controller with a
//               behavioural memory (programmable latency) on every channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;
    import gpu_pkg::*;

    localparam int NC  = 8;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_controller_if #(
        .NUM_CONSUMERS (NC), .NUM_CHANNELS (NCH),
        .ADDR_WIDTH (C_ADDR_WIDTH), .DATA_WIDTH (C_DATA_WIDTH)
    ) bus ();

`ifdef DATA_MEM_CTRL_STATS_EN
    logic [31:0] stat_reads, stat_writes;
`endif

    data_mem_controller #(
        .NUM_CONSUMERS (NC), .NUM_CHANNELS (NCH),
        .ADDR_WIDTH (C_ADDR_WIDTH), .DATA_WIDTH (C_DATA_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DATA_MEM_CTRL_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes)
`endif
    );

    int        n_checks = 0;
    int        n_errors = 0;
    data_t     mem [256];
    int        lat = 1;
    int        rcnt [NCH];
    int        wcnt [NCH];
    bit        rec_en = 1'b0;
    int        order [$];
    int        max_out = 0;
    int        outst;
    logic [NCH-1:0] prev_rv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: ready pulses once the request has been seen on `lat` earlier negedges.
    initial begin
        bus.mem_read_ready  = '0;
        bus.mem_write_ready = '0;
        bus.mem_read_data   = '0;
        for (int c = 0; c < NCH; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (bus.mem_read_valid[c] && !bus.mem_read_ready[c]) begin
                    if (rcnt[c] >= lat) begin
                        bus.mem_read_ready[c] = 1'b1;
                        bus.mem_read_data[c]  = mem[bus.mem_read_address[c]];
                        rcnt[c] = 0;
                    end else rcnt[c]++;
                end else begin
                    bus.mem_read_ready[c] = 1'b0;
                    rcnt[c] = 0;
                end
                if (bus.mem_write_valid[c] && !bus.mem_write_ready[c]) begin
                    if (wcnt[c] >= lat) begin
                        bus.mem_write_ready[c] = 1'b1;
                        mem[bus.mem_write_address[c]] = bus.mem_write_data[c];
                        wcnt[c] = 0;
                    end else wcnt[c]++;
                end else begin
                    bus.mem_write_ready[c] = 1'b0;
                    wcnt[c] = 0;
                end
                if (rec_en && bus.mem_read_valid[c] && !prev_rv[c])
                    order.push_back(int'(bus.mem_read_address[c]) - 'h40);
                prev_rv[c] = bus.mem_read_valid[c];
            end
            if (rec_en) begin
                outst = $countones(bus.mem_read_valid) + $countones(bus.consumer_read_ready);
                if (outst > max_out) max_out = outst;
            end
        end
    end

    task automatic wait_ready(input bit is_wr, input int i);
        for (int k = 0; k < 60; k++) begin
            if (is_wr ? bus.consumer_write_ready[i] : bus.consumer_read_ready[i]) break;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input int i, input logic [7:0] addr, input logic [7:0] exp);
        bus.consumer_read_address[i] = addr;
        bus.consumer_read_valid[i]   = 1'b1;
        wait_ready(1'b0, i);
        check("seq_rd_ack", 32'(bus.consumer_read_ready[i]), 32'd1);
        check("seq_rd_data", 32'(bus.consumer_read_data[i]), 32'(exp));
        bus.consumer_read_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input int i, input logic [7:0] addr, input logic [7:0] data);
        bus.consumer_write_address[i] = addr;
        bus.consumer_write_data[i]    = data;
        bus.consumer_write_valid[i]   = 1'b1;
        wait_ready(1'b1, i);
        check("seq_wr_ack", 32'(bus.consumer_write_ready[i]), 32'd1);
        bus.consumer_write_valid[i] = 1'b0;
        @(negedge clk);
        check("seq_wr_mem", 32'(mem[addr]), 32'(data));
    endtask

    initial begin
        int  done;
        bit  seen;
        reset = 1'b0;
        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a ^ 'h5A);

        repeat (3) @(negedge clk);
        check("rst_mem_rv",  32'(bus.mem_read_valid), 32'd0);
        check("rst_mem_wv",  32'(bus.mem_write_valid), 32'd0);
        check("rst_cons_rr", 32'(bus.consumer_read_ready), 32'd0);
        check("rst_cons_wr", 32'(bus.consumer_write_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single read: valid in cycle 1, request in cycle 2, memory ready in 3, ack in 4.
        mem[8'h10] = 8'hAB;
        bus.consumer_read_address[3] = 8'h10;
        bus.consumer_read_valid[3]   = 1'b1;
        @(negedge clk);
        check("rd_req_valid", 32'(bus.mem_read_valid), 32'b01);
        check("rd_req_addr",  32'(bus.mem_read_address[0]), 32'h10);
        @(negedge clk);
        check("rd_ack_early", 32'(bus.consumer_read_ready[3]), 32'd0);
        @(negedge clk);
        check("rd_ack",  32'(bus.consumer_read_ready[3]), 32'd1);
        check("rd_data", 32'(bus.consumer_read_data[3]), 32'hAB);
        @(negedge clk);
        check("rd_ack_hold", 32'(bus.consumer_read_ready[3]), 32'd1);
        bus.consumer_read_valid[3] = 1'b0;
        @(negedge clk);
        check("rd_ack_drop", 32'(bus.consumer_read_ready), 32'd0);

        // Single write on consumer 0.
        bus.consumer_write_address[0] = 8'h20;
        bus.consumer_write_data[0]    = 8'h55;
        bus.consumer_write_valid[0]   = 1'b1;
        @(negedge clk);
        check("wr_req_valid", 32'(bus.mem_write_valid), 32'b01);
        check("wr_req_addr",  32'(bus.mem_write_address[0]), 32'h20);
        check("wr_req_data",  32'(bus.mem_write_data[0]), 32'h55);
        wait_ready(1'b1, 0);
        check("wr_ack", 32'(bus.consumer_write_ready[0]), 32'd1);
        check("wr_mem", 32'(mem[8'h20]), 32'h55);
        bus.consumer_write_valid[0] = 1'b0;
        @(negedge clk);
        check("wr_ack_drop", 32'(bus.consumer_write_ready), 32'd0);

        // Read and write together on one consumer: read goes out first.
        mem[8'h30] = 8'h3C;
        bus.consumer_read_address[4]  = 8'h30;
        bus.consumer_write_address[4] = 8'h31;
        bus.consumer_write_data[4]    = 8'h77;
        bus.consumer_read_valid[4]    = 1'b1;
        bus.consumer_write_valid[4]   = 1'b1;
        @(negedge clk);
        check("rw_first_rd", 32'(bus.mem_read_valid), 32'b01);
        check("rw_first_wv", 32'(bus.mem_write_valid), 32'b00);
        wait_ready(1'b0, 4);
        check("rw_rd_data", 32'(bus.consumer_read_data[4]), 32'h3C);
        bus.consumer_read_valid[4] = 1'b0;
        wait_ready(1'b1, 4);
        check("rw_wr_ack", 32'(bus.consumer_write_ready[4]), 32'd1);
        check("rw_wr_mem", 32'(mem[8'h31]), 32'h77);
        bus.consumer_write_valid[4] = 1'b0;
        @(negedge clk);

        // Contention: restart arbitration from pointer 0, 8 readers, latency 3.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        lat = 3;
        for (int i = 0; i < NC; i++) begin
            mem[8'h40 + i] = 8'(8'h80 + i);
            bus.consumer_read_address[i] = 8'(8'h40 + i);
        end
        order.delete();
        max_out = 0;
        rec_en  = 1'b1;
        bus.consumer_read_valid = '1;
        done = 0;
        for (int cyc = 0; cyc < 300 && done < NC; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (bus.consumer_read_valid[i] && bus.consumer_read_ready[i]) begin
                    check("cont_data", 32'(bus.consumer_read_data[i]), 32'(8'h80 + i));
                    bus.consumer_read_valid[i] = 1'b0;
                    done++;
                end
            end
        end
        repeat (2) @(negedge clk);
        check("cont_done", 32'(done), 32'(NC));
        check("cont_ngrant", 32'(order.size()), 32'(NC));
        for (int i = 0; i < order.size(); i++) check("cont_order", 32'(order[i]), 32'(i));
        check("cont_max_outstanding", 32'(max_out <= NCH), 32'd1);

        // Fairness across the wrap: after 7 was served, 0 goes ahead of 7.
        order.delete();
        lat = 1;
        bus.consumer_read_valid[7] = 1'b1;
        bus.consumer_read_valid[0] = 1'b1;
        done = 0;
        for (int cyc = 0; cyc < 60 && done < 2; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (bus.consumer_read_valid[i] && bus.consumer_read_ready[i]) begin
                    bus.consumer_read_valid[i] = 1'b0;
                    done++;
                end
            end
        end
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        check("wrap_ngrant", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check("wrap_first",  32'(order[0]), 32'd0);
            check("wrap_second", 32'(order[1]), 32'd7);
        end

        // Mid-operation reset while channel 1 waits on memory.
        lat = 20;
        bus.consumer_read_address[2] = 8'h42;
        bus.consumer_read_address[5] = 8'h45;
        bus.consumer_read_valid[2]   = 1'b1;
        bus.consumer_read_valid[5]   = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_pre_busy", 32'(bus.mem_read_valid), 32'b11);
        #2 reset = 1'b0;
        #1;
        check("mrst_mem_rv",   32'(bus.mem_read_valid), 32'd0);
        check("mrst_mem_addr", 32'(bus.mem_read_address), 32'd0);
        check("mrst_cons_rr",  32'(bus.consumer_read_ready), 32'd0);
        check("mrst_cons_rd",  32'(bus.consumer_read_data[7:0]), 32'd0);
        bus.consumer_read_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (|bus.consumer_read_ready || |bus.mem_read_valid) seen = 1'b1;
        end
        check("mrst_no_stale_ack", 32'(seen), 32'd0);

        // Back-to-back traffic after reset: 5 reads, 3 writes.
        lat = 1;
        for (int k = 0; k < 5; k++) begin
            mem[8'h60 + k] = 8'(8'hC0 + k);
            do_read(1, 8'(8'h60 + k), 8'(8'hC0 + k));
        end
        for (int k = 0; k < 3; k++) do_write(6, 8'(8'h70 + k), 8'(8'h90 + k));
`ifdef DATA_MEM_CTRL_STATS_EN
        check("stat_reads",  stat_reads,  32'd5);
        check("stat_writes", stat_writes, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Sits directly downstream of the per-thread load-store units.
- Collects every LSU's data-memory read/write request and arbitrates them round-robin onto a small number of external data-memory channels.
- Holds each channel for one transaction, then returns the read data or write acknowledge to the requesting LSU.
- Provides the `mem_read_ready` / `mem_write_ready` pulses that LSUs wait on in their WAITING state.

Parameters:
- NUM_CONSUMERS, 8, number of LSU request ports (threads per core)
- NUM_CHANNELS, 2, number of concurrent external memory channels (1..NUM_CONSUMERS)
- ADDR_WIDTH, 8, data memory address width
- DATA_WIDTH, 8, data word width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- consumer_read_valid  in  [NUM_CONSUMERS]  LSU read request
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_WIDTH]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid / ack to LSU
- consumer_read_data  out  [NUM_CONSUMERS][DATA_WIDTH]  returned read data
- consumer_write_valid  in  [NUM_CONSUMERS]  LSU write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_WIDTH]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_WIDTH]  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write ack to LSU
- mem_read_valid  out  [NUM_CHANNELS]  channel read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_WIDTH]  channel read address
- mem_read_ready  in  [NUM_CHANNELS]  memory read completion
- mem_read_data  in  [NUM_CHANNELS][DATA_WIDTH]  memory read data
- mem_write_valid  out  [NUM_CHANNELS]  channel write request
- mem_write_address  out  [NUM_CHANNELS][ADDR_WIDTH]  channel write address
- mem_write_data  out  [NUM_CHANNELS][DATA_WIDTH]  channel write data
- mem_write_ready  in  [NUM_CHANNELS]  memory write completion

Behaviour:
- Reset (`reset` == 0, async):
  - All registered outputs clear to 0.
  - Every channel returns to CH_IDLE; all claim bits and channel consumer ids clear; round-robin pointer rr_ptr = 0.
  - Any in-flight memory transaction is abandoned; no ack is issued after reset releases.
- Per-channel FSM, with states CH_IDLE, CH_READ_WAITING, CH_WRITE_WAITING, CH_RELAY_READ, CH_RELAY_WRITE.
- Eligibility: consumer i is eligible when (read_valid[i] | write_valid[i]) and claimed[i] == 0.
- Grant rules:
  - At most one grant per cycle, always to the lowest-index channel in CH_IDLE.
  - The winner is the first eligible consumer searching upward from rr_ptr, wrapping modulo NUM_CONSUMERS.
  - On a grant: claimed[i] <= 1 and rr_ptr <= (i+1) mod NUM_CONSUMERS.
  - If read_valid and write_valid are both set on one consumer, read is served first; the write is served by a later grant.
- CH_IDLE to WAITING (registered, visible the cycle after the grant):
  - Read grant: mem_read_valid <= 1, mem_read_address <= consumer_read_address[i]; go to CH_READ_WAITING.
  - Write grant: mem_write_valid <= 1, mem_write_address / mem_write_data <= the consumer values; go to CH_WRITE_WAITING.
- CH_READ_WAITING: on mem_read_ready, mem_read_valid <= 0, consumer_read_data[i] <= mem_read_data, consumer_read_ready[i] <= 1; go to CH_RELAY_READ.
- CH_WRITE_WAITING: on mem_write_ready, mem_write_valid <= 0, consumer_write_ready[i] <= 1; go to CH_RELAY_WRITE.
- CH_RELAY_*: once the consumer's matching valid is 0, ready[i] <= 0, claimed[i] <= 0, return to CH_IDLE.
  - The freed channel and consumer are eligible again the following cycle, not the same cycle.
- Latency: minimum 4 cycles from consumer valid rising to consumer ready, with zero-wait memory (grant, request, ready, ack).
- Boundary cases:
  - All channels busy: requests wait; no starvation, guaranteed by round-robin.
  - rr_ptr wraps from NUM_CONSUMERS-1 to 0.
  - A consumer dropping valid while its channel is WAITING is a protocol violation; the channel still completes and then relays.
  - mem_*_ready arriving while not WAITING is ignored.
- Address and data are passed through unmodified; no width conversion.

Optional Feature:
- Macro DATA_MEM_CTRL_STATS_EN. When defined, add two outputs:
  - stat_reads [31:0]: increments on every read completion (mem_read_ready taken in CH_READ_WAITING).
  - stat_writes [31:0]: increments on every write completion.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package (gpu_pkg): `mem_channel_state_t` enum, plus `data_t` and `data_memory_address_t` bound to DATA_WIDTH / ADDR_WIDTH.
- One sub-module: `rr_arbiter`, a combinational priority search from rr_ptr over the eligible mask. It outputs grant_valid and grant_idx; rr_ptr is owned by the parent.

Test Plan:
- Single read: consumer 3 reads addr 0x10, memory returns 0xAB one cycle after request → consumer_read_data[3] = 0xAB, ready high 4 cycles after valid, drops after valid falls.
- Single write: consumer 0 writes 0x55 to 0x20 → mem_write_valid on channel 0 with addr 0x20 / data 0x55; consumer_write_ready[0] pulses after mem_write_ready.
- Contention: all 8 consumers read at once, NUM_CHANNELS = 2, memory latency 3 → grants in order 0,1,2,…,7, never more than 2 outstanding, all 8 complete.
- Fairness/wrap: after consumer 7 is served, consumers 7 and 0 request again → consumer 0 is granted before 7.
- Mid-operation reset: assert reset while channel 1 is in CH_READ_WAITING → all outputs 0 immediately (async); after release, no consumer_read_ready is issued for the old request.
- Stats (DATA_MEM_CTRL_STATS_EN): 5 reads + 3 writes → stat_reads = 5, stat_writes = 3.
